// File: rtl/udl_cmd_gen.sv
// Command front-end for the up/down/load counter: synchronizes and debounces three
// push-buttons, detects presses and arbitrates them into exclusive single-cycle pulses.
module udl_cmd_gen #(
  parameter int n         = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_btn,
  input  logic         down_btn,
  input  logic         load_btn,
  input  logic [n-1:0] sw_in,
  output logic         up,
  output logic         down,
  output logic         load,
  output logic [n-1:0] in
);

  localparam int            CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  // Channel index: 0 = up, 1 = down, 2 = load; lower index wins arbitration.
  logic [2:0]    btn_p0, btn_p1;
  logic [n-1:0]  sw_p0, sw_p1;
  logic [2:0]    db;
  logic [CW-1:0] cnt [3];
  logic [2:0]    pend;
  logic [2:0]    rise;
  logic [2:0]    grant;

  function automatic logic [2:0] pick_first(input logic [2:0] req);
    logic [2:0] g;
    g    = 3'b000;
    g[0] = req[0];
    g[1] = req[1] & ~req[0];
    g[2] = req[2] & ~(|req[1:0]);
    return g;
  endfunction

  // A press is the edge on which the debounced level is about to flip 0->1.
  always_comb begin
    rise = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rise[i] = btn_p1[i] & ~db[i] & (cnt[i] == CNT_MAX);
    end
  end

  // Grants come from the flags as they stand before the edge, so a flag set
  // this edge waits at least one cycle before it can be issued.
  assign grant = pick_first(pend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      sw_p0  <= '0;
      sw_p1  <= '0;
      db     <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
      pend   <= '0;
      up     <= 1'b0;
      down   <= 1'b0;
      load   <= 1'b0;
      in     <= '0;
    end else begin
      // stage p0 -> p1: two-flop synchronizers
      btn_p0 <= {load_btn, down_btn, up_btn};
      btn_p1 <= btn_p0;
      sw_p0  <= sw_in;
      sw_p1  <= sw_p0;

      // debounce: accept a level only after DB_CYCLES consecutive disagreeing samples
      for (int i = 0; i < 3; i++) begin
        if (btn_p1[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= btn_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end

      // arbitration: one pending flag per channel, repeated presses merge
      pend <= (pend & ~grant) | rise;
      up   <= grant[0];
      down <= grant[1];
      load <= grant[2];
      if (grant[2]) begin
        in <= sw_p1;
      end
    end
  end

endmodule

// File: doc/udl_cmd_gen.md
# udl_cmd_gen

Command front-end for the up/down/load counter. Takes three raw, asynchronous push-button inputs and a quasi-static switch bus. Synchronizes and debounces each button, detects press edges, and arbitrates them into mutually exclusive single-cycle `up`/`down`/`load` pulses. Drives the counter's `up`, `down`, `load` and `in` inputs directly, with a stable load value.

## Interface
Parameters:
- `n`, default 4: width of the load value bus.
- `DB_CYCLES`, default 4: consecutive stable synchronized cycles required to accept a level change; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserts immediately on 0, releases synchronously to `clk` from the next edge).
- `up_btn`  in  1  raw, asynchronous, bouncing button.
- `down_btn`  in  1  raw, asynchronous, bouncing button.
- `load_btn`  in  1  raw, asynchronous, bouncing button.
- `sw_in`  in  n  raw switch bus, quasi-static.
- `up`  out  1  single-cycle increment pulse (registered).
- `down`  out  1  single-cycle decrement pulse (registered).
- `load`  out  1  single-cycle load pulse (registered).
- `in`  out  n  load value, registered, stable outside load capture.

## Operation
- Reset (`rst`=0): all synchronizer flops, debounced levels, debounce counters, pending flags, `up`, `down`, `load` and `in` clear to 0.
- Synchronizer: each button and each `sw_in` bit passes through two flops; the second stage is `s`.
- Debounce, per button, with debounced level `db` and counter `cnt` (width ceil(log2(DB_CYCLES))):
  - If `s`==`db`: `cnt`<=0.
  - Else if `cnt`==DB_CYCLES-1: `db`<=`s` and `cnt`<=0.
  - Else: `cnt`<=`cnt`+1.
  - Releases (1->0) are debounced identically.
- Press detect: on the edge where `db` goes 0->1, that channel's pending flag sets. A new press on a channel whose flag is already set merges into it; there is no queueing beyond one.
- Arbiter, every edge:
  - Among pending flags, the highest priority is issued: up > down > load.
  - The issued flag clears and its output is registered high for exactly one cycle. The other outputs are 0.
  - If no flag is pending, all three outputs are 0.
  - At most one output is high in any cycle.
- Same-edge set and issue: a flag set on the same edge it would be issued is not issued that edge. Issue decisions use flag values before the edge.
- Load value: on the edge that registers `load`=1, `in` <= synchronized `sw_in`. Otherwise `in` holds. `in` therefore changes together with the `load` pulse.
- Reset mid-operation clears pending presses and any in-flight pulse. There is no pulse after reset release until a fresh debounced press occurs.

## Timing
- Press latency: raw input first sampled high at edge k, held stable.
  - Edge k+1: `s`=1.
  - Edges k+2..k+1+DB_CYCLES: counting; `db`=1 and pending set at edge k+1+DB_CYCLES.
  - Edge k+2+DB_CYCLES: output high for exactly one cycle.
  - DB_CYCLES=4 gives output high between edges k+6 and k+7.
- Glitch rejection: any synchronized excursion shorter than DB_CYCLES cycles produces no `db` change and no pulse.
- Simultaneous presses whose pending flags set on the same edge issue in consecutive cycles, ordered up, down, load.
- Continuous hold of a button produces exactly one pulse; the next pulse needs a debounced release then a press.
- Minimum spacing between pulses of one channel: 2·DB_CYCLES cycles (press plus release debounce).

## Test plan
- Reset check: drive `rst`=0 mid-cycle with outputs active. Required: `up`/`down`/`load`/`in` = 0 immediately and no pulse after release until a new press.
- Clean press, DB_CYCLES=4: `up_btn` rises before edge 1 and is held. Required: `up`=1 only between edges 7 and 8; `down`=`load`=0 throughout.
- Bounce rejection: `down_btn` toggles 1,0,1,0 on successive cycles, then holds 1. Required: exactly one `down` pulse, 6 edges after the final stable rise is sampled. Also drive a 3-cycle-only high pulse; required: no pulse.
- Simultaneous press: all three buttons rise on the same cycle. Required: `up`, `down`, `load` in consecutive cycles, in that order, never overlapping.
- Load capture, n=4: `sw_in`=4'hA set 10 cycles before the `load_btn` press, `sw_in` changed to 4'h3 after the pulse. Required: `in` becomes 4'hA on the `load` pulse edge and stays 4'hA.
- Hold and repeat: hold `up_btn` for 50 cycles, release, then press again. Required: two `up` pulses total, the second no earlier than 2·DB_CYCLES cycles after the first.
